// File: rtl/bcd2bin_pkg.sv
// Shared state encodings, default sizing and the per-nibble adjust step for bcd2bin.
package bcd2bin_pkg;

    localparam int NDIG_DEF      = 4;
    localparam int BIN_W_DEF     = 14;
    localparam int DONE_HOLD_DEF = 31;

    localparam logic [2:0] START  = 3'b000;
    localparam logic [2:0] SHIFT  = 3'b001;
    localparam logic [2:0] ADJUST = 3'b010;
    localparam logic [2:0] END1   = 3'b011;

    // Reverse double-dabble correction: a shifted nibble >= 8 borrowed a 10 from above.
    function automatic logic [3:0] dabble_adj(input logic [3:0] nib);
        return (nib >= 4'd8) ? (nib - 4'd3) : nib;
    endfunction

endpackage

// File: rtl/ctrl_bcd2bin.sv
// Sequencer for bcd2bin: START/SHIFT/ADJUST/END1 FSM with iteration and done-hold counters.
// Latency: 2*BIN_W edges from accept to done (accept straight to END1 on a bad digit); no backpressure, init ignored while busy.
module ctrl_bcd2bin
    import bcd2bin_pkg::*;
#(
    parameter int BIN_W     = BIN_W_DEF,
    parameter int DONE_HOLD = DONE_HOLD_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic init,
    input  logic bad_digit,
    output logic ld,
    output logic sh,
    output logic adj,
    output logic done,
    output logic busy
);

    localparam int CW = $clog2(BIN_W + 1);
    localparam int HW = $clog2(DONE_HOLD + 1);
    localparam logic [CW-1:0] LAST_CNT  = CW'(BIN_W);
    localparam logic [HW-1:0] HOLD_LAST = HW'(DONE_HOLD - 1);

    logic [2:0]    state;
    logic [2:0]    state_nxt;
    logic [CW-1:0] count;
    logic [HW-1:0] hold;
    logic          last;

    assign last = (count == LAST_CNT);

    always_comb begin
        state_nxt = START;
        case (state)
            START:   state_nxt = init ? (bad_digit ? END1 : SHIFT) : START;
            SHIFT:   state_nxt = ADJUST;
            ADJUST:  state_nxt = last ? END1 : SHIFT;
            END1:    state_nxt = (hold == HOLD_LAST) ? START : END1;
            default: state_nxt = START;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= START;
            count <= '0;
            hold  <= '0;
        end else begin
            state <= state_nxt;
            if (ld) begin
                count <= '0;
            end else if (sh) begin
                count <= count + CW'(1);
            end
            // Hold counter only runs in END1 so every done window is exactly DONE_HOLD long.
            if (state == END1) begin
                hold <= hold + HW'(1);
            end else begin
                hold <= '0;
            end
        end
    end

    assign ld   = (state == START) && init;
    assign sh   = (state == SHIFT);
    assign adj  = (state == ADJUST);
    assign done = (state == END1);
    assign busy = (state != START);

endmodule

// File: rtl/bcd2bin.sv
// Sequential BCD-to-binary converter (reverse double-dabble); optional digit check under BCD2BIN_BCD_CHECK_EN.
// Latency: done rises 2*BIN_W edges after init is accepted and stays high DONE_HOLD cycles; no backpressure, init ignored while busy.
module bcd2bin
    import bcd2bin_pkg::*;
#(
    parameter int NDIG      = NDIG_DEF,
    parameter int BIN_W     = BIN_W_DEF,
    parameter int DONE_HOLD = DONE_HOLD_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                init,
    input  logic [4*NDIG-1:0]   bcd_in,
    output logic [BIN_W-1:0]    bin_out,
    output logic                busy,
    output logic                done,
    output logic                err
);

    logic [4*NDIG-1:0] bcd_r;
    logic [4*NDIG-1:0] bcd_adj;
    logic              bad_digit;
    logic              ld;
    logic              sh;
    logic              adj;

    ctrl_bcd2bin #(
        .BIN_W     (BIN_W),
        .DONE_HOLD (DONE_HOLD)
    ) u_ctrl (
        .clk       (clk),
        .rst       (rst),
        .init      (init),
        .bad_digit (bad_digit),
        .ld        (ld),
        .sh        (sh),
        .adj       (adj),
        .done      (done),
        .busy      (busy)
    );

    always_comb begin
        bcd_adj = '0;
        for (int i = 0; i < NDIG; i++) begin
            bcd_adj[4*i +: 4] = dabble_adj(bcd_r[4*i +: 4]);
        end
    end

    // {bcd_r, bin_out} behaves as one right-shifting register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bcd_r   <= '0;
            bin_out <= '0;
        end else if (ld) begin
            bcd_r   <= bcd_in;
            bin_out <= '0;
        end else if (sh) begin
            bcd_r   <= {1'b0, bcd_r[4*NDIG-1:1]};
            bin_out <= {bcd_r[0], bin_out[BIN_W-1:1]};
        end else if (adj) begin
            bcd_r   <= bcd_adj;
        end
    end

`ifdef BCD2BIN_BCD_CHECK_EN
    logic [NDIG-1:0] nib_bad;

    always_comb begin
        nib_bad = '0;
        for (int i = 0; i < NDIG; i++) begin
            nib_bad[i] = (bcd_in[4*i +: 4] > 4'd9);
        end
    end

    assign bad_digit = |nib_bad;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err <= 1'b0;
        end else if (ld) begin
            err <= bad_digit;
        end
    end
`else
    assign bad_digit = 1'b0;
    assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_bcd2bin.sv
// Bench for bcd2bin: table vectors, hand-written timing/reset sequences and a random sweep, scoreboarded.
module tb_bcd2bin;
    timeunit 1ns;
    timeprecision 1ns;

    logic        clk;
    logic        rst;
    logic        init;
    logic [15:0] bcd_in;
    logic [13:0] bin_out;
    logic        busy;
    logic        done;
    logic        err;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [15:0] bcd;
        logic [13:0] bin;
    } vec_t;

    typedef struct {
        logic [13:0] bin;
        logic        err;
        logic        chk_bin;
    } exp_t;

    vec_t tbl[8];
    exp_t sb[$];

    bcd2bin u_dut (
        .clk     (clk),
        .rst     (rst),
        .init    (init),
        .bcd_in  (bcd_in),
        .bin_out (bin_out),
        .busy    (busy),
        .done    (done),
        .err     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish (got timeout, required completion)");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    // Called at #1 after a rising edge with the DUT in START; returns at #1 after the edge where busy fell.
    task automatic conv(input logic [15:0] bcd, input logic [13:0] exp_bin, input logic exp_err,
                        input logic chk_bin, input int exp_lat, input int exp_busy,
                        input logic hold, input int poke);
        exp_t e;
        int   lat;
        int   busy_n;
        int   done_n;
        int   first_done;
        e.bin = exp_bin;
        e.err = exp_err;
        e.chk_bin = chk_bin;
        init   = 1'b1;
        bcd_in = bcd;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (!hold) init = 1'b0;
        bcd_in = 16'h5555;
        chk("accept_busy", int'(busy), 1);
        lat = 0;
        busy_n = 0;
        done_n = 0;
        first_done = -1;
        while (busy && lat < 300) begin
            busy_n++;
            if (done) begin
                done_n++;
                if (first_done < 0) begin
                    first_done = lat;
                    if (sb.size() == 0) begin
                        chk("scoreboard_empty", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        if (e.chk_bin) chk($sformatf("bin_out[%h]", bcd), int'(bin_out), int'(e.bin));
                        chk($sformatf("err[%h]", bcd), int'(err), int'(e.err));
                    end
                end
            end
            @(posedge clk);
            #1;
            lat++;
            if (lat == poke) begin
                init   = 1'b1;
                bcd_in = 16'h9999;
            end else if (lat == poke + 1) begin
                init   = 1'b0;
            end
        end
        chk($sformatf("done_latency[%h]", bcd), first_done, exp_lat);
        chk($sformatf("busy_cycles[%h]", bcd), busy_n, exp_busy);
        chk($sformatf("done_cycles[%h]", bcd), done_n, exp_busy - exp_lat);
        if (first_done < 0 && sb.size() != 0) void'(sb.pop_front());
    endtask

    initial begin
        logic [3:0] d[4];
        logic [15:0] rb;
        int          rv;

        tbl[0] = '{16'h1234, 14'd1234};
        tbl[1] = '{16'h9999, 14'd9999};
        tbl[2] = '{16'h0000, 14'd0};
        tbl[3] = '{16'h0042, 14'd42};
        tbl[4] = '{16'h0001, 14'd1};
        tbl[5] = '{16'h5000, 14'd5000};
        tbl[6] = '{16'h8765, 14'd8765};
        tbl[7] = '{16'h0999, 14'd999};

        rst    = 1'b1;
        init   = 1'b0;
        bcd_in = 16'h0;
        #12;
        chk("reset_bin_out", int'(bin_out), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_err", int'(err), 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 8; i++) begin
            conv(tbl[i].bcd, tbl[i].bin, 1'b0, 1'b1, 28, 59, 1'b0, -10);
        end

        // init pulse and bcd_in change mid-conversion must be ignored
        conv(16'h1234, 14'd1234, 1'b0, 1'b1, 28, 59, 1'b0, 5);

        // held init restarts on the first START cycle after END1
        conv(16'h0777, 14'd777, 1'b0, 1'b1, 28, 59, 1'b1, -10);
        conv(16'h0314, 14'd314, 1'b0, 1'b1, 28, 59, 1'b0, -10);

`ifdef BCD2BIN_BCD_CHECK_EN
        conv(16'h12A4, 14'd0, 1'b1, 1'b1, 0, 31, 1'b0, -10);
        conv(16'h0005, 14'd5, 1'b0, 1'b1, 28, 59, 1'b0, -10);
`else
        conv(16'h12A4, 14'd0, 1'b0, 1'b0, 28, 59, 1'b0, -10);
`endif

        // asynchronous reset mid-conversion
        init   = 1'b1;
        bcd_in = 16'h1234;
        @(posedge clk);
        #1;
        init = 1'b0;
        repeat (10) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("midrst_bin_out", int'(bin_out), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_done", int'(done), 0);
        chk("midrst_err", int'(err), 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("postrst_idle", int'(busy), 0);
        conv(16'h0042, 14'd42, 1'b0, 1'b1, 28, 59, 1'b0, -10);

        // random sweep over valid digits
        for (int n = 0; n < 200; n++) begin
            for (int k = 0; k < 4; k++) d[k] = 4'($urandom_range(0, 9));
            rb = {d[3], d[2], d[1], d[0]};
            rv = int'(d[3]) * 1000 + int'(d[2]) * 100 + int'(d[1]) * 10 + int'(d[0]);
            conv(rb, 14'(rv), 1'b0, 1'b1, 28, 59, 1'b0, -10);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
